regularization_mc: RTL and testbench

REGULARIZATION_MC -- requirements
Module: regularization_mc

---
 rtl/regularization_mc_if.sv | 36 +++
 rtl/regularization_mc.sv | 191 +++++++++++++++++++
 tb/tb_regularization_mc.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regularization_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : regularization_mc_if
//  Purpose  : Bundles the channel inputs, runtime configuration and the
//             regularised outputs of regularization_mc into one port.
//  Ports    : i_signal/i_enable/i_cfg_load/i_debounce/i_delay/i_clear are
//             driven by the master; o_signal/o_edge/o_hold/o_suppress are
//             driven by the slave (the regulariser).
//  Revision : 1.0  initial release
// ============================================================================
interface regularization_mc_if #(
  parameter int N  = 4,
  parameter int CW = 16
);
  logic [N-1:0]  i_signal;
  logic          i_enable;
  logic          i_cfg_load;
  logic [CW-1:0] i_debounce;
  logic [CW-1:0] i_delay;
  logic          i_clear;
  logic [N-1:0]  o_signal;
  logic [N-1:0]  o_edge;
  logic [N-1:0]  o_hold;
  logic [N-1:0]  o_suppress;

  modport master (
    output i_signal, i_enable, i_cfg_load, i_debounce, i_delay, i_clear,
    input  o_signal, o_edge, o_hold, o_suppress
  );

  modport slave (
    input  i_signal, i_enable, i_cfg_load, i_debounce, i_delay, i_clear,
    output o_signal, o_edge, o_hold, o_suppress
  );
endinterface
`default_nettype wire

// File: rtl/regularization_mc.sv
`default_nettype none
// ============================================================================
//  Module   : regularization_mc
//  Purpose  : N-channel input regulariser. Each raw input is synchronised,
//             debounced for DEB_eff cycles, then the output is frozen for a
//             DLY_eff-cycle hold-off. Activity seen during hold-off raises a
//             sticky suppress flag.
//  Ports    : i_clk   - clock, rising edge
//             i_reset - synchronous active-high reset
//             bus     - regularization_mc_if slave modport (channel inputs,
//                       enable, config load/values, clear; o_signal, o_edge,
//                       o_hold, o_suppress)
//  Note     : the interface instance must use the same N and CW.
//  Revision : 1.0  initial release
// ============================================================================
module regularization_mc #(
  parameter int           N             = 4,
  parameter int           CW            = 16,
  parameter int           DEBOUNCE_TIME = 5000,
  parameter int           DELAY         = 20,
  parameter int           SYNC_STAGES   = 2,
  parameter logic [N-1:0] INIT          = {N{1'b0}}
) (
  input  logic               i_clk,
  input  logic               i_reset,
  regularization_mc_if.slave bus
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser (keeps shifting even while i_enable is low)
  // --------------------------------------------------------------------------
  logic [N-1:0] sync_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_s = bus.i_signal;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT;
        end else begin
          sync_q[0] <= bus.i_signal;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign sync_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Shared configuration registers (load is honoured regardless of enable)
  // --------------------------------------------------------------------------
  logic [CW-1:0] cfg_deb_q;
  logic [CW-1:0] cfg_dly_q;
  logic [CW-1:0] deb_eff;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cfg_deb_q <= CW'(DEBOUNCE_TIME);
      cfg_dly_q <= CW'(DELAY);
    end else if (bus.i_cfg_load) begin
      cfg_deb_q <= bus.i_debounce;
      cfg_dly_q <= bus.i_delay;
    end
  end

  // A zero debounce length behaves like one: commit on the first edge.
  assign deb_eff = (cfg_deb_q == '0) ? CNT_ONE : cfg_deb_q;

  // --------------------------------------------------------------------------
  // Per-channel FSM
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < N; i++) begin : g_ch
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      // Length captured when a count starts, so a config load mid-count only
      // affects counts that begin afterwards.
      logic [CW-1:0] len_q, len_d;
      logic          sig_q, sig_d;
      logic          edge_q, edge_d;
      logic          sup_q, sup_d;
      logic          diff;
      logic          commit;

      assign diff = sync_s[i] ^ sig_q;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sig_d   = sig_q;
        edge_d  = 1'b0;
        sup_d   = sup_q;
        commit  = 1'b0;

        if (bus.i_enable) begin
          if (bus.i_clear) sup_d = 1'b0;

          unique case (state_q)
            ST_IDLE: begin
              if (diff) begin
                if (deb_eff == CNT_ONE) begin
                  commit = 1'b1;
                end else begin
                  state_d = ST_DEBOUNCE;
                  cnt_d   = CNT_ONE;
                  len_d   = deb_eff;
                end
              end
            end
            ST_DEBOUNCE: begin
              if (!diff) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
              end else if (cnt_q + CNT_ONE == len_q) begin
                commit = 1'b1;
              end else begin
                // cnt_q < len_q - 1 here, so the increment cannot wrap
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            ST_HOLD: begin
              // Set is evaluated after the clear so it wins on a tie.
              if (diff) sup_d = 1'b1;
              if (cnt_q >= len_q) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            default: begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          endcase

          if (commit) begin
            sig_d  = ~sig_q;
            edge_d = 1'b1;
            if (cfg_dly_q == '0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = CNT_ONE;
              len_d   = cfg_dly_q;
            end
          end
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          len_q   <= '0;
          sig_q   <= INIT[i];
          edge_q  <= 1'b0;
          sup_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          len_q   <= len_d;
          sig_q   <= sig_d;
          edge_q  <= edge_d;
          sup_q   <= sup_d;
        end
      end

      assign bus.o_signal[i]   = sig_q;
      assign bus.o_edge[i]     = edge_q;
      assign bus.o_hold[i]     = (state_q == ST_HOLD);
      assign bus.o_suppress[i] = sup_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regularization_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regularization_mc
//  Purpose  : Self-checking bench for regularization_mc. A behavioural model
//             (run length / remaining hold-off counters per channel) is
//             stepped every clock and compared with all outputs; directed
//             scenarios add latency/pulse-count checks, then a random phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regularization_mc;

  localparam int           N    = 4;
  localparam int           CW   = 8;
  localparam int           DEB0 = 6;
  localparam int           DLY0 = 3;
  localparam int           SS   = 2;
  localparam logic [N-1:0] INIT = 4'b1010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regularization_mc_if #(.N(N), .CW(CW)) bus ();

  regularization_mc #(
    .N(N), .CW(CW), .DEBOUNCE_TIME(DEB0), .DELAY(DLY0),
    .SYNC_STAGES(SS), .INIT(INIT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  logic [N-1:0] m_out, m_edge, m_sup;
  logic [N-1:0] m_hist [SS];
  int           m_run      [N];  // consecutive differing cycles in this count
  int           m_len      [N];  // debounce length captured at count start
  int           m_hold_rem [N];  // hold-off cycles still to go
  int           m_cfg_deb, m_cfg_dly;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    logic [N-1:0] s;
    logic [N-1:0] set;
    if (rst) begin
      m_out = INIT; m_edge = '0; m_sup = '0;
      for (int k = 0; k < SS; k++) m_hist[k] = INIT;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0; m_len[c] = 0; m_hold_rem[c] = 0;
      end
      m_cfg_deb = DEB0; m_cfg_dly = DLY0;
    end else begin
      s = m_hist[SS-1];
      for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = bus.i_signal;
      m_edge = '0;
      if (bus.i_enable) begin
        set = '0;
        for (int c = 0; c < N; c++) begin
          if (m_hold_rem[c] > 0) begin
            if (s[c] != m_out[c]) set[c] = 1'b1;
            m_hold_rem[c]--;
          end else if (s[c] != m_out[c]) begin
            if (m_run[c] == 0) m_len[c] = (m_cfg_deb < 1) ? 1 : m_cfg_deb;
            m_run[c]++;
            if (m_run[c] == m_len[c]) begin
              m_out[c]      = ~m_out[c];
              m_edge[c]     = 1'b1;
              m_run[c]      = 0;
              m_hold_rem[c] = m_cfg_dly;
            end
          end else begin
            m_run[c] = 0;
          end
        end
        m_sup = (bus.i_clear ? '0 : m_sup) | set;
      end
      if (bus.i_cfg_load) begin
        m_cfg_deb = int'(bus.i_debounce);
        m_cfg_dly = int'(bus.i_delay);
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] mh;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < N; c++) mh[c] = (m_hold_rem[c] > 0);
    chk("o_signal", bus.o_signal, m_out);
    chk("o_edge", bus.o_edge, m_edge);
    chk("o_hold", bus.o_hold, mh);
    chk("o_suppress", bus.o_suppress, m_sup);
  endtask

  task automatic load_cfg(input int deb, input int dly);
    bus.i_cfg_load = 1'b1;
    bus.i_debounce = CW'(deb);
    bus.i_delay    = CW'(dly);
    cycle();
    bus.i_cfg_load = 1'b0;
  endtask

  initial begin
    int           idx, edges, holds, low_seen;
    logic [N-1:0] prev;

    rst            = 1'b1;
    bus.i_signal   = INIT;
    bus.i_enable   = 1'b1;
    bus.i_cfg_load = 1'b0;
    bus.i_debounce = '0;
    bus.i_delay    = '0;
    bus.i_clear    = 1'b0;

    // Reset state
    repeat (3) cycle();
    chk("reset_signal", bus.o_signal, INIT);
    chk("reset_edge", bus.o_edge, '0);
    chk("reset_hold", bus.o_hold, '0);
    chk("reset_suppress", bus.o_suppress, '0);
    rst = 1'b0;
    cycle();

    // Debounce DEB=4, DLY=0: output follows after SS sync edges + 4
    load_cfg(4, 0);
    bus.i_signal[0] = 1'b1;
    idx = 0; edges = 0;
    for (int j = 1; j <= 12; j++) begin
      prev = bus.o_signal;
      cycle();
      if (idx == 0 && bus.o_signal[0] !== prev[0]) idx = j;
      edges += int'(bus.o_edge[0]);
    end
    chk_int("deb4_latency", idx, SS + 4);
    chk_int("deb4_edge_pulses", edges, 1);

    // Glitch: three cycles high on channel 2 is shorter than DEB=4
    bus.i_signal[2] = 1'b1;
    edges = 0;
    for (int j = 1; j <= 15; j++) begin
      cycle();
      if (j == 3) bus.i_signal[2] = 1'b0;
      edges += int'(bus.o_edge[2]);
    end
    chk_int("glitch_output", int'(bus.o_signal[2]), 0);
    chk_int("glitch_edges", edges, 0);

    // Hold-off DEB=1, DLY=5 on channel 0 (currently 1): toggle 0 then back
    load_cfg(1, 5);
    bus.i_signal[0] = 1'b0;
    holds = 0; edges = 0; low_seen = 0;
    for (int j = 1; j <= 18; j++) begin
      cycle();
      if (j == 2) bus.i_signal[0] = 1'b1;
      if (j <= 8) holds += int'(bus.o_hold[0]);
      if (j == 3) low_seen = int'(bus.o_signal[0] == 1'b0);
      edges += int'(bus.o_edge[0]);
    end
    chk_int("holdoff_hold_cycles", holds, 5);
    chk_int("holdoff_first_toggle", low_seen, 1);
    chk_int("holdoff_final_level", int'(bus.o_signal[0]), 1);
    chk_int("holdoff_suppress", int'(bus.o_suppress[0]), 1);
    chk_int("holdoff_edges", edges, 2);
    bus.i_clear = 1'b1;
    cycle();
    bus.i_clear = 1'b0;
    chk("clear_suppress", bus.o_suppress, '0);

    // Runtime config: DEB=10 count in progress, load DEB=2 mid-count
    load_cfg(10, 0);
    bus.i_signal[3] = 1'b0;
    idx = 0;
    for (int j = 1; j <= 16; j++) begin
      prev = bus.o_signal;
      cycle();
      if (idx == 0 && bus.o_signal[3] !== prev[3]) idx = j;
      if (j == 5) begin
        bus.i_cfg_load = 1'b1; bus.i_debounce = CW'(2); bus.i_delay = '0;
      end
      if (j == 6) bus.i_cfg_load = 1'b0;
    end
    chk_int("cfg_old_count_len", idx, SS + 10);
    bus.i_signal[3] = 1'b1;
    idx = 0;
    for (int j = 1; j <= 8; j++) begin
      prev = bus.o_signal;
      cycle();
      if (idx == 0 && bus.o_signal[3] !== prev[3]) idx = j;
    end
    chk_int("cfg_new_count_len", idx, SS + 2);

    // Reset restores DEBOUNCE_TIME
    rst = 1'b1;
    bus.i_signal = INIT;
    repeat (2) cycle();
    rst = 1'b0;
    bus.i_signal[0] = 1'b1;
    idx = 0;
    for (int j = 1; j <= 14; j++) begin
      prev = bus.o_signal;
      cycle();
      if (idx == 0 && bus.o_signal[0] !== prev[0]) idx = j;
    end
    chk_int("reset_deb_revert", idx, SS + DEB0);

    // Freeze 7 cycles mid-debounce on channel 2, then clear vs set tie
    load_cfg(DEB0, 8);
    bus.i_signal[2] = 1'b1;
    idx = 0;
    for (int j = 1; j <= 20; j++) begin
      prev = bus.o_signal;
      cycle();
      if (idx == 0 && bus.o_signal[2] !== prev[2]) idx = j;
      if (j == 4)  bus.i_enable = 1'b0;
      if (j == 11) bus.i_enable = 1'b1;
      if (j == 15) bus.i_signal[2] = 1'b0;
      if (j == 19) bus.i_clear = 1'b1;
      if (j == 20) bus.i_clear = 1'b0;
    end
    chk_int("freeze_resume_latency", idx, SS + DEB0 + 7);
    chk_int("clear_set_tie", int'(bus.o_suppress[2]), 1);

    // Reset while channel 2 is in hold-off
    chk_int("pre_reset_hold", int'(bus.o_hold[2]), 1);
    rst = 1'b1;
    bus.i_signal = INIT;
    cycle();
    chk("midhold_reset_signal", bus.o_signal, INIT);
    chk("midhold_reset_hold", bus.o_hold, '0);
    chk("midhold_reset_suppress", bus.o_suppress, '0);
    rst = 1'b0;

    // Randomised phase against the model
    for (int t = 0; t < 1500; t++) begin
      int r;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 15) == 0) bus.i_signal[c] = ~bus.i_signal[c];
      bus.i_enable   = ($urandom_range(0, 9) != 0);
      bus.i_clear    = bus.i_enable && ($urandom_range(0, 19) == 0);
      bus.i_cfg_load = ($urandom_range(0, 49) == 0);
      r = int'($urandom_range(0, 24));
      bus.i_debounce = (r == 0) ? '1 : CW'($urandom_range(0, 6));
      r = int'($urandom_range(0, 24));
      bus.i_delay    = (r == 0) ? '1 : CW'($urandom_range(0, 6));
      rst            = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
